program_memory: RTL and testbench
=================================

# program_memory

Program memory with an integrated byte-stream loader. It is the responder end of the control unit's instruction-fetch interface: it returns `PM_data` for the `PC` the control unit drives. It also accepts a program image from a host as a valid/ready byte stream and packs the bytes into 16-bit instruction words. While a load is in progress it asserts `cpu_hold`, which the top level ORs into the control unit's `reset`.

## Interface
- `PC_WIDTH`, default 8: fetch address width; memory depth is 2^PC_WIDTH words of 16 bits.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `PC`  in  PC_WIDTH  fetch address from the control unit.
- `PM_data`  out  16  instruction word at `PC`, registered.
- `load_start`  in  1  one-cycle request to begin a load.
- `load_valid`  in  1  `load_byte` is valid.
- `load_byte`  in  8  program byte; the high byte of each word comes first.
- `load_last`  in  1  marks the final byte; qualified by `load_valid`.
- `load_ready`  out  1  loader can accept a byte.
- `cpu_hold`  out  1  high from load start through `load_done`.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `load_error`  out  1  sticky error for the current or most recent load.
- `word_count`  out  PC_WIDTH+1  number of words written in the current or most recent load.

## Operation
- **Byte transfer:** a byte is transferred on a rising edge where `load_valid && load_ready` is true.
- **FSM states:** IDLE, LOAD_HI, LOAD_LO, DONE.
- **IDLE**
  - `load_ready`=0, `cpu_hold`=0.
  - `load_start`=1 → LOAD_HI; clear `word_count` and `load_error`.
- **LOAD_HI**
  - `load_ready`=1, `cpu_hold`=1.
  - Accepted byte is latched as bits 15:8 → LOAD_LO.
  - If `load_last` is set on this byte: write {byte, 8'h00}, set `load_error` (odd byte count), → DONE.
- **LOAD_LO**
  - `load_ready`=1.
  - Accepted byte forms {hi, byte}, written to `mem[word_count]`; `word_count` += 1.
  - `load_last` set → DONE, otherwise → LOAD_HI.
- **Overflow**
  - Any accepted byte when `word_count` == 2^PC_WIDTH is discarded (no write, no wrap to address 0) and sets `load_error`.
  - The FSM keeps alternating HI/LO and still terminates on `load_last`.
- **DONE:** `load_done`=1, `cpu_hold`=1, `load_ready`=0 → IDLE unconditionally.
- **Ignored inputs:** `load_start` outside IDLE is ignored. `load_valid` in IDLE/DONE is ignored.
- **Fetch side**
  - Every cycle, `PM_data` <= `mem[PC]`, regardless of state.
  - Read-first: a read of the address being written that cycle returns the old contents.
- **Memory contents**
  - Undefined at power-up.
  - Not cleared by `reset`.
- **Reset**
  - FSM → IDLE.
  - `PM_data`=0, `load_ready`=0, `cpu_hold`=0, `load_done`=0, `load_error`=0, `word_count`=0.
  - Reset mid-load aborts the load. Words already written remain in memory. A partial high byte is dropped.
  - Reset takes priority over every simultaneous event.

## Timing
- All outputs are registered; none is combinational from inputs.
- Fetch latency is 1 cycle: `PC` sampled at edge N appears on `PM_data` after edge N.
- Load rate is one byte per cycle at full throughput; a word takes 2 cycles.
- **Load start:** `load_start` sampled at edge N → `cpu_hold`=1 and `load_ready`=1 after edge N. The first byte can be accepted at edge N+1.
- **Load end:**
  - Last byte accepted at edge M → `load_done`=1 for the cycle after M.
  - `cpu_hold` falls after edge M+1.
  - `PM_data` reflects the newly written words from edge M+1 onward.
- **Stalls:** `load_valid` low stalls the FSM in place with no timeout. `load_ready` does not drop between bytes of a load.

## Test plan
- **Reset:** hold `reset` 2 cycles with `load_valid`=1 and `load_start`=1 → all outputs 0, `load_ready`=0, and no memory write.
- **Basic load:** `load_start`, then bytes A5, 03, 12, 34 back-to-back, `load_last` on 34 → `word_count`=2, one-cycle `load_done`, `load_error`=0. Afterwards `PC`=0 gives `PM_data`=16'hA503 and `PC`=1 gives 16'h1234, each 1 cycle later.
- **Stalled stream:** same bytes with `load_valid` low 3 cycles between each byte → identical memory contents and `word_count`. `cpu_hold` stays high throughout the gaps.
- **Odd byte count:** bytes 11, 22, 56 with `load_last` on 56 → `mem[1]`=16'h5600, `load_error`=1, `word_count`=2, and `load_done` pulses.
- **Overflow:** with PC_WIDTH=2, send 10 bytes (5 words) → `mem[0..3]` hold the first 4 words, `mem[0]` is not overwritten, `word_count`=4, `load_error`=1.
- **Reset and re-load:**
  - Load 2 bytes, then send `load_start` mid-load → the second `load_start` is ignored.
  - Send 1 more byte, then `reset` → IDLE, `cpu_hold`=0, `word_count`=0, `mem[0]` retained.
  - A new load then proceeds normally.

Source files
------------

// File: rtl/program_memory.sv
// rtl/program_memory.sv - 16-bit program memory with a byte-stream image loader
module program_memory #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] PC,
    output logic [15:0]         PM_data,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [7:0]          load_byte,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [PC_WIDTH:0]   word_count
);

    localparam int DEPTH = 1 << PC_WIDTH;
    localparam logic [PC_WIDTH:0] FULL_COUNT = (PC_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [15:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [PC_WIDTH:0]   count_q, count_d;
    logic                error_q, error_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic [15:0]         pm_data_q;

    logic                accept;
    logic                full;
    logic                we;
    logic [15:0]         wdata;
    logic [PC_WIDTH-1:0] waddr;

    assign accept = load_valid && ready_q;
    assign full   = (count_q == FULL_COUNT);
    // Writes always go to the next free slot; the full check keeps them from wrapping.
    assign waddr  = count_q[PC_WIDTH-1:0];

    // Next-state logic: byte packing, word counting and error tracking; outputs are pre-computed from the next state so they come out registered.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        count_d = count_q;
        error_d = error_q;
        we      = 1'b0;
        wdata   = 16'h0000;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD_HI;
                    count_d = '0;
                    error_d = 1'b0;
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    hi_d = load_byte;
                    if (full) begin
                        error_d = 1'b1;
                    end
                    if (load_last) begin
                        // Odd byte count: the lone high byte becomes a word padded with zero.
                        if (!full) begin
                            we      = 1'b1;
                            wdata   = {load_byte, 8'h00};
                            count_d = count_q + 1'b1;
                        end
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    if (full) begin
                        error_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        wdata   = {hi_q, load_byte};
                        count_d = count_q + 1'b1;
                    end
                    state_d = load_last ? DONE : LOAD_HI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO);
        hold_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // Loader state register with synchronous reset; reset discards any half-assembled word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 8'h00;
            count_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            error_q <= error_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Memory array: no reset so contents survive a reset; a write during reset is suppressed.
    always_ff @(posedge clock) begin
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered fetch port; reads see the contents from before any same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            pm_data_q <= 16'h0000;
        end else begin
            pm_data_q <= mem[PC];
        end
    end

    assign PM_data    = pm_data_q;
    assign load_ready = ready_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - directed self-checking bench for program_memory
module tb_program_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic [1:0]  pc_s;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;

    logic [15:0] pm_data;
    logic        load_ready, cpu_hold, load_done, load_error;
    logic [8:0]  word_count;

    logic [15:0] pm_data_s;
    logic        load_ready_s, cpu_hold_s, load_done_s, load_error_s;
    logic [2:0]  word_count_s;

    int n_checks = 0;
    int n_errors = 0;

    assign pc_s = pc[1:0];

    always #5 clock = ~clock;

    program_memory #(.PC_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .PC         (pc),
        .PM_data    (pm_data),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    program_memory #(.PC_WIDTH(2)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .PC         (pc_s),
        .PM_data    (pm_data_s),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready_s),
        .cpu_hold   (cpu_hold_s),
        .load_done  (load_done_s),
        .load_error (load_error_s),
        .word_count (word_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap);
        int guard;
        load_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
        end
        if (gap > 0) begin
            check("hold_in_gap", cpu_hold, 1'b1);
        end
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        guard = 0;
        while (!load_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            check("ready_timeout", 1'b0, 1'b1);
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read(input string tag, input logic [7:0] a, input logic [15:0] exp);
        pc = a;
        tick();
        check(tag, pm_data, exp);
    endtask

    initial begin
        reset      = 1'b1;
        pc         = 8'h00;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        load_last  = 1'b1;

        // Reset with load inputs active
        tick();
        tick();
        check("rst_pm_data", pm_data, 16'h0000);
        check("rst_ready", load_ready, 1'b0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_error", load_error, 1'b0);
        check("rst_count", word_count, 9'd0);
        reset      = 1'b0;
        load_start = 1'b0;
        load_last  = 1'b0;
        tick();
        check("idle_ignores_valid", load_ready, 1'b0);
        load_valid = 1'b0;

        // Basic load
        start_load();
        check("start_hold", cpu_hold, 1'b1);
        check("start_ready", load_ready, 1'b1);
        send(8'hA5, 1'b0, 0);
        send(8'h03, 1'b0, 0);
        send(8'h12, 1'b0, 0);
        send(8'h34, 1'b1, 0);
        check("basic_done", load_done, 1'b1);
        check("basic_count", word_count, 9'd2);
        check("basic_error", load_error, 1'b0);
        check("basic_ready_done", load_ready, 1'b0);
        check("basic_hold_done", cpu_hold, 1'b1);
        tick();
        check("basic_done_pulse", load_done, 1'b0);
        check("basic_hold_end", cpu_hold, 1'b0);
        read("basic_mem0", 8'd0, 16'hA503);
        read("basic_mem1", 8'd1, 16'h1234);

        // Odd byte count
        start_load();
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h56, 1'b1, 0);
        check("odd_done", load_done, 1'b1);
        check("odd_error", load_error, 1'b1);
        check("odd_count", word_count, 9'd2);
        tick();
        read("odd_mem0", 8'd0, 16'h1122);
        read("odd_mem1", 8'd1, 16'h5600);

        // Stalled stream
        start_load();
        send(8'hA5, 1'b0, 3);
        send(8'h03, 1'b0, 3);
        send(8'h12, 1'b0, 3);
        send(8'h34, 1'b1, 3);
        check("stall_done", load_done, 1'b1);
        check("stall_count", word_count, 9'd2);
        check("stall_error", load_error, 1'b0);
        tick();
        read("stall_mem0", 8'd0, 16'hA503);
        read("stall_mem1", 8'd1, 16'h1234);

        // Overflow: 5 words into the 4-word instance
        start_load();
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), (i == 10), 0);
        end
        check("ovf_done", load_done_s, 1'b1);
        check("ovf_count", word_count_s, 3'd4);
        check("ovf_error", load_error_s, 1'b1);
        check("big_count", word_count, 9'd5);
        check("big_error", load_error, 1'b0);
        tick();
        pc = 8'd0; tick(); check("ovf_mem0", pm_data_s, 16'h0102);
        pc = 8'd1; tick(); check("ovf_mem1", pm_data_s, 16'h0304);
        pc = 8'd2; tick(); check("ovf_mem2", pm_data_s, 16'h0506);
        pc = 8'd3; tick(); check("ovf_mem3", pm_data_s, 16'h0708);

        // Reset and re-load
        start_load();
        send(8'hAA, 1'b0, 0);
        send(8'hBB, 1'b0, 0);
        start_load();
        check("restart_ignored_count", word_count, 9'd1);
        check("restart_ignored_ready", load_ready, 1'b1);
        send(8'hCC, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hold", cpu_hold, 1'b0);
        check("abort_ready", load_ready, 1'b0);
        check("abort_count", word_count, 9'd0);
        read("abort_mem0", 8'd0, 16'hAABB);
        read("abort_mem1", 8'd1, 16'h0304);
        start_load();
        send(8'h77, 1'b0, 0);
        send(8'h88, 1'b1, 0);
        check("reload_done", load_done, 1'b1);
        check("reload_count", word_count, 9'd1);
        check("reload_error", load_error, 1'b0);
        tick();
        read("reload_mem0", 8'd0, 16'h7788);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
